timer_ctrl: RTL
===============

# timer_ctrl

Bus-facing controller for the prescaled `timer` block in the OneTactMips peripheral space. It holds software-visible shadow copies of `scale` and `period` and drives them to the timer. It sequences the timer through hold/run/one-shot states via the timer's reset input. It detects counter wrap-around and latches an interrupt-pending flag and an expiry count for the CPU.

## Interface
- No parameters.
- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `addr` input 2: word index. 0=CTRL, 1=SCALE, 2=PERIOD, 3=STATUS.
- `we` input 1: write strobe, single-cycle, takes effect at the next edge.
- `wdata` input 32: write data.
- `rdata` output 32: combinational read of the register at `addr`.
- `tmr_cntr` input 16: timer's current `cntr` value.
- `tmr_scale` output 15: drives timer `scale`.
- `tmr_period` output 16: drives timer `period`.
- `tmr_reset` output 1: registered, drives timer `reset`. 1 holds the timer at zero.
- `irq` output 1: combinational `PEND & IE`.

## Operation
- Register map, write side:
  - CTRL: bit0 EN, bit1 ONESHOT, bit2 IE.
  - SCALE: bits[14:0] go to the shadow scale.
  - PERIOD: bits[15:0] go to the shadow period.
  - STATUS: write bit0=1 clears PEND; write bit8=1 clears EXPCNT. Other bits are ignored.
- Register map, read side:
  - CTRL: {29'b0, IE, ONESHOT, EN}.
  - SCALE: zero-extended shadow scale.
  - PERIOD: zero-extended shadow period.
  - STATUS: {tmr_cntr, EXPCNT[7:0], 6'b0, RUNNING, PEND}.
- Reset values:
  - EN=ONESHOT=IE=0.
  - Shadow scale 0; shadow period 16'hFFFF.
  - `tmr_scale`=0, `tmr_period`=16'hFFFF.
  - `tmr_reset`=1, PEND=0, EXPCNT=0, `cntr_q`=0, state IDLE.
  - Hence `irq`=0.
- `cntr_q`: registered copy of `tmr_cntr`, forced to 0 while in IDLE.
- Expiry event: `state==RUN && cntr_q!=0 && tmr_cntr==0`.
  - With period 0 the timer never leaves 0, so no event ever fires. This is required behaviour, not an error.
- FSM, two states (RUNNING = state is RUN):
  - IDLE:
    - `tmr_reset`=1.
    - `tmr_scale`/`tmr_period` load from the shadows every cycle.
    - EN=1 (already set, or being written this cycle) → RUN.
  - RUN:
    - `tmr_reset`=0.
    - Shadow writes do NOT reach the timer until the next expiry or the return to IDLE.
    - Transitions:
      - CTRL write with EN=0 → IDLE.
      - Expiry with ONESHOT=1 → IDLE, and hardware clears EN.
      - Expiry with ONESHOT=0 → stay in RUN; load shadows into `tmr_scale`/`tmr_period` at that edge.
- Every expiry event: PEND←1; EXPCNT←EXPCNT+1, saturating at 255.
- Simultaneous events:
  - Expiry and PEND-clear write in the same cycle: PEND ends 1 (set wins).
  - Expiry and EXPCNT-clear in the same cycle: EXPCNT ends 1.
  - Expiry and CTRL write with EN=0: PEND/EXPCNT update and state goes to IDLE.
  - Expiry and CTRL write with EN=1, ONESHOT=1: the one-shot rule applies using the new ONESHOT value. The write and the hardware clear both land at the same edge; the hardware clear of EN wins.
- `reset` mid-run returns everything to reset values at the next edge. `tmr_reset`=1 from that edge.

## Timing
- Writes commit at the rising edge that ends the `we` cycle, call it edge W.
- CTRL write EN=1 at edge W: state=RUN and `tmr_reset`=0 from edge W.
- Timer count sequence (S=0, period P): first timer increment at edge W+1, `tmr_cntr` reaches P at edge W+P, wraps to 0 at edge W+P+1.
- PEND timing: the event is seen in the cycle after edge W+P+1, so PEND=1 from edge W+P+2.
- Subsequent expiries (periodic mode, S=0) occur every P+1 cycles.
- `irq` follows PEND/IE with no added latency.
- `rdata` is purely combinational, zero latency; a read in the same cycle as a write returns the old value.
- The one-shot return to IDLE and `tmr_reset`=1 take effect at the same edge PEND is set.

## Test plan
- Reset: assert `reset` 2 cycles → `tmr_reset`=1, `tmr_period`=16'hFFFF, `tmr_scale`=0, `irq`=0, all reads 0 except PERIOD=32'h0000FFFF.
- Periodic run: SCALE=0, PERIOD=3, CTRL=3'b101 → PEND and `irq` rise 5 edges after the CTRL write. EXPCNT increments every 4 cycles; after clearing PEND it re-asserts 4 cycles later.
- One-shot: PERIOD=2, CTRL=3'b011 → exactly one expiry; EN reads 0, RUNNING=0, `tmr_reset`=1; EXPCNT stays 1 over 50 further cycles.
- Shadow isolation: running with PERIOD=3, write PERIOD=7 → `tmr_period` stays 3 until the next expiry edge, then 7. The following interval is 8 cycles.
- Races:
  - PEND-clear on the expiry cycle → PEND=1.
  - 300 expiries with no clear → EXPCNT=255.
  - EXPCNT-clear on the expiry cycle → EXPCNT=1.
- Period 0 and mid-run reset:
  - PERIOD=0, EN=1 → no PEND for 100 cycles.
  - Running periodic mode, pulse `reset` → next edge state IDLE, `tmr_reset`=1, EN=0, PEND=0.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: bus-facing controller for the prescaled timer block.
// Keeps software shadows of scale/period, sequences the timer between
// hold and run through its reset input, detects counter wrap-around and
// latches an interrupt-pending flag plus a saturating expiry count.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   addr, we, wdata    register write port (0=CTRL 1=SCALE 2=PERIOD 3=STATUS)
//   rdata              combinational read of the register at addr
//   tmr_cntr           timer's current counter value
//   tmr_scale          scale driven to the timer
//   tmr_period         period driven to the timer
//   tmr_reset          registered timer hold (1 = timer held at zero)
//   irq                combinational PEND & IE
module timer_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [15:0] tmr_cntr,
   output logic [14:0] tmr_scale,
   output logic [15:0] tmr_period,
   output logic        tmr_reset,
   output logic        irq
);

   localparam int unsigned SCALE_W  = 15;
   localparam int unsigned PERIOD_W = 16;
   localparam int unsigned EXPCNT_W = 8;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_SCALE  = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam logic [PERIOD_W-1:0] PERIOD_RST = '1;
   localparam logic [EXPCNT_W-1:0] EXPCNT_MAX = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e               state_q,   state_d;
   logic                 en_q,      en_d;
   logic                 oneshot_q, oneshot_d;
   logic                 ie_q,      ie_d;
   logic [SCALE_W-1:0]   sscale_q,  sscale_d;
   logic [PERIOD_W-1:0]  speriod_q, speriod_d;
   logic [SCALE_W-1:0]   tscale_q,  tscale_d;
   logic [PERIOD_W-1:0]  tperiod_q, tperiod_d;
   logic                 treset_q,  treset_d;
   logic                 pend_q,    pend_d;
   logic [EXPCNT_W-1:0]  expcnt_q,  expcnt_d;
   logic [PERIOD_W-1:0]  cntr_q,    cntr_d;

   logic wr_ctrl_c;
   logic wr_scale_c;
   logic wr_period_c;
   logic wr_status_c;
   logic expiry_c;
   logic reload_c;
   logic running_c;
   logic wdata_unused_c;

   // Write decode and wrap detection (counter fell from nonzero to zero while running)
   always_comb begin
      wr_ctrl_c   = we && (addr == ADDR_CTRL);
      wr_scale_c  = we && (addr == ADDR_SCALE);
      wr_period_c = we && (addr == ADDR_PERIOD);
      wr_status_c = we && (addr == ADDR_STATUS);
      running_c   = (state_q == ST_RUN);
      expiry_c    = running_c && (cntr_q != '0) && (tmr_cntr == '0);
      // Timer-facing copies track the shadows while idle, and only on expiry while running
      reload_c    = (state_q == ST_IDLE) || expiry_c;
   end

   assign wdata_unused_c = ^wdata[31:16];

   // Next-state and register update logic
   always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      oneshot_d = oneshot_q;
      ie_d      = ie_q;
      sscale_d  = sscale_q;
      speriod_d = speriod_q;
      tscale_d  = tscale_q;
      tperiod_d = tperiod_q;
      pend_d    = pend_q;
      expcnt_d  = expcnt_q;
      cntr_d    = cntr_q;
      treset_d  = treset_q;

      if (wr_ctrl_c) begin
         en_d      = wdata[0];
         oneshot_d = wdata[1];
         ie_d      = wdata[2];
      end
      if (wr_scale_c) begin
         sscale_d = wdata[SCALE_W-1:0];
      end
      if (wr_period_c) begin
         speriod_d = wdata[PERIOD_W-1:0];
      end

      // Software clears first so a same-cycle expiry wins
      if (wr_status_c && wdata[0]) begin
         pend_d = 1'b0;
      end
      if (wr_status_c && wdata[8]) begin
         expcnt_d = '0;
      end
      if (expiry_c) begin
         pend_d = 1'b1;
         if (expcnt_d != EXPCNT_MAX) begin
            expcnt_d = expcnt_d + EXPCNT_W'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (en_d) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // One-shot uses the ONESHOT value being written this cycle; hardware EN clear wins
            if (expiry_c && oneshot_d) begin
               state_d = ST_IDLE;
               en_d    = 1'b0;
            end else if (!en_d) begin
               state_d = ST_IDLE;
            end
         end
      endcase

      if (reload_c) begin
         tscale_d  = sscale_q;
         tperiod_d = speriod_q;
      end

      cntr_d   = (state_q == ST_IDLE) ? '0 : tmr_cntr;
      treset_d = (state_d == ST_IDLE);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         en_q      <= 1'b0;
         oneshot_q <= 1'b0;
         ie_q      <= 1'b0;
         sscale_q  <= '0;
         speriod_q <= PERIOD_RST;
         tscale_q  <= '0;
         tperiod_q <= PERIOD_RST;
         treset_q  <= 1'b1;
         pend_q    <= 1'b0;
         expcnt_q  <= '0;
         cntr_q    <= '0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         oneshot_q <= oneshot_d;
         ie_q      <= ie_d;
         sscale_q  <= sscale_d;
         speriod_q <= speriod_d;
         tscale_q  <= tscale_d;
         tperiod_q <= tperiod_d;
         treset_q  <= treset_d;
         pend_q    <= pend_d;
         expcnt_q  <= expcnt_d;
         cntr_q    <= cntr_d;
      end
   end

   // Combinational register read
   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_CTRL:   rdata = {29'b0, ie_q, oneshot_q, en_q};
         ADDR_SCALE:  rdata = {17'b0, sscale_q};
         ADDR_PERIOD: rdata = {16'b0, speriod_q};
         ADDR_STATUS: rdata = {tmr_cntr, expcnt_q, 6'b0, running_c, pend_q};
      endcase
   end

   assign tmr_scale  = tscale_q;
   assign tmr_period = tperiod_q;
   assign tmr_reset  = treset_q;
   assign irq        = pend_q & ie_q;

endmodule
